// File: rtl/serial_work_loader.sv
// Turns the UART byte stream into fixed-length hasher work packets, checks the
// length at end-of-packet, and hands the result over with a valid/ack handshake.
module serial_work_loader #(
    parameter int PAYLOAD_BYTES = 44,
    parameter int WORK_WIDTH    = 8 * PAYLOAD_BYTES,
    parameter int CNT_WIDTH     = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_data_ready,
    input  logic [7:0]            rx_data,
    input  logic                  rx_endofpacket,
    output logic [WORK_WIDTH-1:0] work_data,
    output logic                  work_valid,
    input  logic                  work_ack,
    output logic                  overrun,
    output logic [7:0]            good_pkts,
    output logic [7:0]            bad_pkts,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DISCARD
    } state_t;

    localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(PAYLOAD_BYTES);
    localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);

    state_t                  state;
    state_t                  st_byte;
    logic [CNT_WIDTH-1:0]    cnt;
    logic [CNT_WIDTH-1:0]    cnt_byte;
    logic [WORK_WIDTH-1:0]   sr;
    logic [WORK_WIDTH-1:0]   sr_byte;
    logic                    commit;
    logic                    drop;

    // Byte first, then end-of-packet judged on the post-byte state and count,
    // so a final byte arriving together with the strobe is part of the packet.
    always_comb begin
        st_byte  = state;
        cnt_byte = cnt;
        sr_byte  = sr;
        commit   = 1'b0;
        drop     = 1'b0;

        if (rx_data_ready) begin
            case (state)
                IDLE: begin
                    sr_byte  = {sr[WORK_WIDTH-9:0], rx_data};
                    cnt_byte = ONE;
                    st_byte  = RECV;
                end
                RECV: begin
                    if (cnt < FULL) begin
                        sr_byte  = {sr[WORK_WIDTH-9:0], rx_data};
                        cnt_byte = cnt + ONE;
                    end else begin
                        st_byte = DISCARD;
                    end
                end
                default: ;
            endcase
        end

        if (rx_endofpacket) begin
            case (st_byte)
                RECV: begin
                    if (cnt_byte == FULL) commit = 1'b1;
                    else                  drop   = 1'b1;
                end
                DISCARD: drop = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            sr         <= '0;
            work_data  <= '0;
            work_valid <= 1'b0;
            overrun    <= 1'b0;
            good_pkts  <= '0;
            bad_pkts   <= '0;
            busy       <= 1'b0;
        end else begin
            sr <= sr_byte;

            if (commit || drop) begin
                state <= IDLE;
                cnt   <= '0;
                busy  <= 1'b0;
            end else begin
                state <= st_byte;
                cnt   <= cnt_byte;
                busy  <= (st_byte != IDLE);
            end

            // A commit outranks a same-cycle ack; the ack consumed the old packet.
            if (commit) begin
                work_data  <= sr_byte;
                work_valid <= 1'b1;
                good_pkts  <= good_pkts + 8'd1;
                if (work_valid && !work_ack) overrun <= 1'b1;
            end else if (work_ack) begin
                work_valid <= 1'b0;
            end

            if (drop) bad_pkts <= bad_pkts + 8'd1;
        end
    end

endmodule

// File: doc/serial_work_loader.md
Name: serial_work_loader

Overview:
- Sequences the UART receive path into the hasher work pipeline.
- Consumes the byte stream and packet-framing strobes from the RS-232 receiver.
- Assembles a fixed-length work packet (midstate plus data tail), validates its length at end-of-packet, and presents it to the hashers with a valid/ack handshake.
- Keeps wrap-around good-packet and bad-packet counters for debug LEDs and status readback.

Parameters:
- PAYLOAD_BYTES, default 44: required packet length in bytes (32 midstate + 12 data).
- WORK_WIDTH, default 352: 8*PAYLOAD_BYTES; width of the work bus. Do not override independently.
- CNT_WIDTH, default 6: width of the byte counter; must satisfy 2^CNT_WIDTH > PAYLOAD_BYTES.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- rx_data_ready  in  1  one-cycle strobe; rx_data is valid.
- rx_data  in  8  received byte.
- rx_endofpacket  in  1  one-cycle strobe; receiver line has gone idle after a burst.
- work_data  out  WORK_WIDTH  last accepted work packet; first received byte in bits [WORK_WIDTH-1:WORK_WIDTH-8].
- work_valid  out  1  work_data holds an unconsumed packet.
- work_ack  in  1  hasher has taken work_data.
- overrun  out  1  sticky; a new packet was committed while work_valid was still 1.
- good_pkts  out  8  count of committed packets, wraps 255->0.
- bad_pkts  out  8  count of discarded packets, wraps 255->0.
- busy  out  1  high while a packet is being received (state != IDLE).

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - State goes to IDLE and the byte counter to 0.
  - work_data=0, work_valid=0, overrun=0, good_pkts=0, bad_pkts=0, busy=0.
  - The shift register is cleared.
  - Reset mid-packet abandons the packet; bad_pkts is not incremented.
- Shift register:
  - Width WORK_WIDTH.
  - On each accepted byte: sr <= {sr[WORK_WIDTH-9:0], rx_data}.
- States:
  - IDLE:
    - rx_data_ready: shift the byte in, byte count=1, go to RECV.
    - rx_endofpacket alone: ignored (no counter change).
  - RECV:
    - rx_data_ready with count<PAYLOAD_BYTES: shift the byte in, count+1.
    - rx_data_ready with count==PAYLOAD_BYTES: go to DISCARD (the byte is not shifted).
    - rx_endofpacket with count==PAYLOAD_BYTES: commit, go to IDLE.
    - rx_endofpacket with count<PAYLOAD_BYTES: bad_pkts+1, go to IDLE.
  - DISCARD:
    - Ignore all bytes.
    - On rx_endofpacket: bad_pkts+1, go to IDLE.
- Same-cycle rx_data_ready and rx_endofpacket: the byte is processed first (including any RECV->DISCARD decision), then the end-of-packet evaluation uses the updated count and state.
  - Example: byte 44 arriving with end-of-packet in RECV commits.
  - Example: byte 45 arriving with end-of-packet in RECV counts as bad.
- Commit (registered; visible the cycle after the end-of-packet strobe):
  - work_data <= sr, work_valid <= 1, good_pkts+1.
  - If work_valid was already 1 and work_ack is 0 that cycle, set overrun <= 1. overrun clears only on reset.
- Handshake:
  - work_ack with work_valid=1 clears work_valid the next cycle.
  - work_ack with work_valid=0 has no effect.
  - Simultaneous commit and ack: commit wins, work_valid stays 1, no overrun.
- Stability:
  - work_data changes only on commit or reset.
  - The shift register contents after a bad packet are never exposed.
- Latency: 1 clk from the rx_endofpacket strobe to work_valid rising.
- Counters: plain binary wrap, with no saturation.
- busy: 1 in RECV and in DISCARD.

Test Plan:
- Valid packet:
  - Stimulus: reset, then 44 bytes 0x01..0x2C, then end-of-packet.
  - Response: work_valid=1 one cycle later; work_data[351:344]=0x01, work_data[7:0]=0x2C; good_pkts=1, bad_pkts=0.
- Short packet:
  - Stimulus: 43 bytes, then end-of-packet.
  - Response: work_valid stays 0, work_data unchanged, bad_pkts=1, state returns to IDLE (busy=0).
- Long packet:
  - Stimulus: 46 bytes, then end-of-packet.
  - Response: bad_pkts=1, work_data unchanged; a following valid 44-byte packet commits correctly with good_pkts=1.
- Handshake and overrun:
  - Stimulus: two valid packets with no work_ack.
  - Response: work_data holds the second packet, overrun=1, good_pkts=2.
  - Then: pulse work_ack; work_valid=0 next cycle and overrun stays 1.
- Simultaneous events:
  - Stimulus A: byte 44 and end-of-packet in the same cycle. Response: commit.
  - Stimulus B: commit coincident with work_ack. Response: work_valid stays 1, overrun=0.
- Reset and wrap:
  - Stimulus: assert reset after 20 bytes. Response: busy=0, bad_pkts=0; the next valid packet commits.
  - Stimulus: 256 valid packets. Response: good_pkts wraps to 0.
